multicycle_control: RTL and testbench

Multi-cycle control unit for the lab processor core. It sequences each instruction through fetch, decode, execute, memory and writeback states, with ready/acknowledge handshakes to instruction and data memory. It decodes the R-type and immediate ALU classes plus load, store, branch-equal and jump. It drives all datapath select and write-enable strobes and keeps a retired-instruction count.

---
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/multicycle_control.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory bundle: decoded fields and acks in, select/strobe outputs out.
// master = control unit, slave = datapath and memories.
interface multicycle_control_if #(
  parameter int ALUOP_W  = 4,
  parameter int RETIRE_W = 16
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                zero;
  logic                imem_ack;
  logic                dmem_ack;
  logic                imem_req;
  logic                dmem_req;
  logic                dmem_we;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic                shift;
  logic                imm_sel;
  logic                reg_write;
  logic                mem_to_reg;
  logic                ill_instr;
  logic [2:0]          state;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  opcode, funct, zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src_a,
           alu_src_b, alu_op, shift, imm_sel, reg_write, mem_to_reg, ill_instr,
           state, retired
  );

  modport slave (
    output opcode, funct, zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src_a,
           alu_src_b, alu_op, shift, imm_sel, reg_write, mem_to_reg, ill_instr,
           state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB/BRANCH sequencer; outputs are combinational from state and inputs.
// Memory waits stretch FETCH/MEM until the ack; J 2, BEQ 3, ALU/SW 4, LW 5 cycles with zero-wait memory.
module multicycle_control #(
  parameter int ALUOP_W  = 4,
  parameter int RETIRE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    BRANCH = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_R, CL_IMM, CL_LW, CL_SW, CL_BEQ, CL_J, CL_ILL
  } class_e;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_SLL = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  class_e              cls;
  logic [3:0]          r_op;
  logic [3:0]          exe_op;
  logic                retire;

  logic       o_imem_req, o_dmem_req, o_dmem_we, o_ir_write, o_pc_write;
  logic [1:0] o_pc_src, o_alu_src_b;
  logic       o_alu_src_a, o_shift, o_imm_sel, o_reg_write, o_mem_to_reg, o_ill_instr;
  logic [3:0] o_op;

  always_comb begin
    cls  = CL_ILL;
    r_op = OP_ADD;
    case (bus.opcode)
      6'b000000: begin
        cls = CL_R;
        case (bus.funct)
          6'b000000: r_op = OP_SLL;
          6'b000010: r_op = OP_SRL;
          6'b100000: r_op = OP_ADD;
          6'b100010: r_op = OP_SUB;
          6'b100100: r_op = OP_AND;
          6'b100101: r_op = OP_OR;
          6'b101010: r_op = OP_SLT;
          default:   cls  = CL_ILL;
        endcase
      end
      6'b111111: cls = CL_IMM;
      6'b100011: cls = CL_LW;
      6'b101011: cls = CL_SW;
      6'b000100: cls = CL_BEQ;
      6'b000010: cls = CL_J;
      default:   cls = CL_ILL;
    endcase
  end

  // EXEC and WB share this so WB keeps presenting the EXEC operation.
  always_comb begin
    case (cls)
      CL_R:    exe_op = r_op;
      CL_IMM:  exe_op = OP_AND;
      default: exe_op = OP_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = bus.imem_ack ? DECODE : FETCH;
      DECODE: begin
        case (cls)
          CL_J, CL_ILL: state_d = FETCH;
          CL_BEQ:       state_d = BRANCH;
          default:      state_d = EXEC;
        endcase
      end
      EXEC: begin
        case (cls)
          CL_R, CL_IMM:  state_d = WB;
          CL_LW, CL_SW:  state_d = MEM;
          default:       state_d = FETCH;
        endcase
      end
      MEM: begin
        if (!bus.dmem_ack)     state_d = MEM;
        else if (cls == CL_LW) state_d = WB;
        else                   state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 2'd0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'd0;
    o_op         = OP_AND;
    o_imm_sel    = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_ill_instr  = 1'b0;
    retire       = 1'b0;
    case (state_q)
      FETCH: begin
        o_imem_req  = 1'b1;
        o_alu_src_b = 2'd1;
        o_op        = OP_ADD;
        o_ir_write  = bus.imem_ack;
        o_pc_write  = bus.imem_ack;
      end
      DECODE: begin
        o_alu_src_b = 2'd3;
        o_op        = OP_ADD;
        if (cls == CL_J) begin
          o_pc_write = 1'b1;
          o_pc_src   = 2'd2;
          retire     = 1'b1;
        end else if (cls == CL_ILL) begin
          o_ill_instr = 1'b1;
        end
      end
      EXEC: begin
        o_op = exe_op;
        case (cls)
          CL_R: o_alu_src_a = 1'b1;
          CL_IMM: begin
            o_alu_src_b = 2'd2;
            o_imm_sel   = 1'b1;
          end
          CL_LW, CL_SW: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'd2;
          end
          default: ;
        endcase
      end
      MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (cls == CL_SW);
        retire     = bus.dmem_ack && (cls == CL_SW);
      end
      WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = (cls == CL_LW);
        o_op         = exe_op;
        o_imm_sel    = (cls == CL_IMM);
        retire       = 1'b1;
      end
      BRANCH: begin
        o_alu_src_a = 1'b1;
        o_op        = OP_SUB;
        o_pc_src    = 2'd1;
        o_pc_write  = bus.zero;
        retire      = 1'b1;
      end
      default: ;
    endcase
    o_shift = (o_op == OP_SLL) || (o_op == OP_SRL);
  end

  assign retired_d = retired_q + RETIRE_W'(retire);

  // Everything is forced low while reset is held so no request or strobe leaks out.
  assign bus.imem_req   = rst_n & o_imem_req;
  assign bus.dmem_req   = rst_n & o_dmem_req;
  assign bus.dmem_we    = rst_n & o_dmem_we;
  assign bus.ir_write   = rst_n & o_ir_write;
  assign bus.pc_write   = rst_n & o_pc_write;
  assign bus.pc_src     = rst_n ? o_pc_src : 2'd0;
  assign bus.alu_src_a  = rst_n & o_alu_src_a;
  assign bus.alu_src_b  = rst_n ? o_alu_src_b : 2'd0;
  assign bus.alu_op     = rst_n ? ALUOP_W'(o_op) : '0;
  assign bus.shift      = rst_n & o_shift;
  assign bus.imm_sel    = rst_n & o_imm_sel;
  assign bus.reg_write  = rst_n & o_reg_write;
  assign bus.mem_to_reg = rst_n & o_mem_to_reg;
  assign bus.ill_instr  = rst_n & o_ill_instr;
  assign bus.state      = state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues the hand-derived output vector,
// a negedge monitor pops it and compares against the DUT.
module tb_multicycle_control;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       shift;
    logic       imm_sel;
    logic       reg_write;
    logic       mem_to_reg;
    logic       ill_instr;
    logic [2:0] state;
    logic [7:0] retired;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_control_if #(.ALUOP_W(4), .RETIRE_W(8)) bus ();

  multicycle_control #(.ALUOP_W(4), .RETIRE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t       exp_q[$];
  string      name_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_ret  = 8'd0;
  logic [5:0] cur_op   = 6'd0;
  logic [5:0] cur_fn   = 6'd0;
  logic       cur_z    = 1'b0;
  logic       noise    = 1'b0;

  function automatic vec_t actual();
    vec_t a;
    a.imem_req   = bus.imem_req;
    a.dmem_req   = bus.dmem_req;
    a.dmem_we    = bus.dmem_we;
    a.ir_write   = bus.ir_write;
    a.pc_write   = bus.pc_write;
    a.pc_src     = bus.pc_src;
    a.alu_src_a  = bus.alu_src_a;
    a.alu_src_b  = bus.alu_src_b;
    a.alu_op     = bus.alu_op;
    a.shift      = bus.shift;
    a.imm_sel    = bus.imm_sel;
    a.reg_write  = bus.reg_write;
    a.mem_to_reg = bus.mem_to_reg;
    a.ill_instr  = bus.ill_instr;
    a.state      = bus.state;
    a.retired    = bus.retired;
    return a;
  endfunction

  always @(negedge clk) begin
    vec_t  e;
    vec_t  a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  function automatic vec_t v(input logic [2:0] st);
    vec_t r;
    r         = '0;
    r.state   = st;
    r.retired = exp_ret;
    return r;
  endfunction

  task automatic step(input string n, input logic ia, input logic da, input vec_t e);
    bus.opcode   = cur_op;
    bus.funct    = cur_fn;
    bus.zero     = cur_z;
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int waits);
    vec_t e;
    for (int i = 0; i <= waits; i++) begin
      e           = v(3'd0);
      e.imem_req  = 1'b1;
      e.alu_src_b = 2'd1;
      e.alu_op    = 4'h2;
      e.ir_write  = (i == waits);
      e.pc_write  = (i == waits);
      step("fetch", i == waits, noise, e);
    end
  endtask

  task automatic do_decode(input logic j, input logic ill);
    vec_t e;
    e           = v(3'd1);
    e.alu_src_b = 2'd3;
    e.alu_op    = 4'h2;
    e.pc_write  = j;
    e.pc_src    = j ? 2'd2 : 2'd0;
    e.ill_instr = ill;
    step(ill ? "decode_ill" : "decode", noise, noise, e);
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [3:0] op, input logic sh, input int fw);
    vec_t e;
    cur_op = 6'b000000;
    cur_fn = fn;
    do_fetch(fw);
    do_decode(1'b0, 1'b0);
    e           = v(3'd2);
    e.alu_src_a = 1'b1;
    e.alu_op    = op;
    e.shift     = sh;
    step("r_exec", noise, noise, e);
    e           = v(3'd4);
    e.reg_write = 1'b1;
    e.alu_op    = op;
    e.shift     = sh;
    step("r_wb", noise, noise, e);
    exp_ret++;
  endtask

  task automatic run_imm();
    vec_t e;
    cur_op = 6'b111111;
    cur_fn = 6'b100000;
    do_fetch(0);
    do_decode(1'b0, 1'b0);
    e           = v(3'd2);
    e.alu_src_b = 2'd2;
    e.imm_sel   = 1'b1;
    step("imm_exec", 1'b0, 1'b0, e);
    e           = v(3'd4);
    e.reg_write = 1'b1;
    e.imm_sel   = 1'b1;
    step("imm_wb", 1'b0, 1'b0, e);
    exp_ret++;
  endtask

  task automatic run_mem(input logic is_sw, input int dw);
    vec_t e;
    cur_op = is_sw ? 6'b101011 : 6'b100011;
    cur_fn = 6'd0;
    do_fetch(0);
    do_decode(1'b0, 1'b0);
    e           = v(3'd2);
    e.alu_src_a = 1'b1;
    e.alu_src_b = 2'd2;
    e.alu_op    = 4'h2;
    step("ls_exec", 1'b0, 1'b0, e);
    for (int i = 0; i <= dw; i++) begin
      e          = v(3'd3);
      e.dmem_req = 1'b1;
      e.dmem_we  = is_sw;
      step(is_sw ? "sw_mem" : "lw_mem", 1'b0, i == dw, e);
    end
    if (!is_sw) begin
      e            = v(3'd4);
      e.reg_write  = 1'b1;
      e.mem_to_reg = 1'b1;
      e.alu_op     = 4'h2;
      step("lw_wb", 1'b0, 1'b0, e);
    end
    exp_ret++;
  endtask

  task automatic run_beq(input logic z);
    vec_t e;
    cur_op = 6'b000100;
    cur_z  = z;
    do_fetch(0);
    do_decode(1'b0, 1'b0);
    e           = v(3'd5);
    e.alu_src_a = 1'b1;
    e.alu_op    = 4'h6;
    e.pc_src    = 2'd1;
    e.pc_write  = z;
    step("beq_branch", 1'b0, 1'b0, e);
    exp_ret++;
    cur_z = 1'b0;
  endtask

  task automatic run_j();
    cur_op = 6'b000010;
    do_fetch(0);
    do_decode(1'b1, 1'b0);
    exp_ret++;
  endtask

  task automatic run_ill(input logic [5:0] op, input logic [5:0] fn);
    cur_op = op;
    cur_fn = fn;
    do_fetch(0);
    do_decode(1'b0, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    vec_t e;
    bus.opcode   = 6'd0;
    bus.funct    = 6'd0;
    bus.zero     = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset: everything low, even with acks asserted.
    step("reset", 1'b1, 1'b1, v(3'd0));
    step("reset", 1'b0, 1'b0, v(3'd0));
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1) begin
        failures++;
        $display("FAIL release: imem_req %b", bus.imem_req);
    end
    checks++;
    if (bus.alu_src_b !== 2'd1) begin
        failures++;
        $display("FAIL release: alu_src_b %0d", bus.alu_src_b);
    end
    checks++;
    if (bus.alu_op !== 4'h2) begin
        failures++;
        $display("FAIL release: alu_op %h", bus.alu_op);
    end
    checks++;
    if (bus.state !== 3'd0) begin
        failures++;
        $display("FAIL release: state %0d", bus.state);
    end

    run_r(6'b100010, 4'h6, 1'b0, 3);
    run_r(6'b000010, 4'hA, 1'b1, 0);
    run_r(6'b000000, 4'h9, 1'b1, 0);
    run_r(6'b100000, 4'h2, 1'b0, 1);
    run_r(6'b100100, 4'h0, 1'b0, 0);
    noise = 1'b1;
    run_r(6'b100101, 4'h1, 1'b0, 2);
    run_r(6'b101010, 4'h7, 1'b0, 0);
    noise = 1'b0;
    run_imm();
    run_mem(1'b0, 2);
    run_mem(1'b1, 0);
    run_mem(1'b1, 1);
    run_beq(1'b1);
    run_beq(1'b0);
    run_j();
    run_ill(6'b010101, 6'b000000);
    run_ill(6'b000000, 6'b000001);
    checks++;
    if (bus.retired !== exp_ret) begin
        failures++;
        $display("FAIL ill_retired: got %h expected %h", bus.retired, exp_ret);
    end

    // Reset asserted while waiting in MEM: request drops and the counter clears at once.
    cur_op = 6'b100011;
    do_fetch(0);
    do_decode(1'b0, 1'b0);
    e           = v(3'd2);
    e.alu_src_a = 1'b1;
    e.alu_src_b = 2'd2;
    e.alu_op    = 4'h2;
    step("ls_exec", 1'b0, 1'b0, e);
    e          = v(3'd3);
    e.dmem_req = 1'b1;
    step("lw_mem", 1'b0, 1'b0, e);
    rst_n   = 1'b0;
    exp_ret = 8'd0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0) begin
        failures++;
        $display("FAIL reset_in_mem: dmem_req %b", bus.dmem_req);
    end
    checks++;
    if (bus.state !== 3'd0) begin
        failures++;
        $display("FAIL reset_in_mem: state %0d", bus.state);
    end
    checks++;
    if (bus.retired !== 8'd0) begin
        failures++;
        $display("FAIL reset_in_mem: retired %h", bus.retired);
    end
    step("reset_in_mem", 1'b0, 1'b1, v(3'd0));
    rst_n = 1'b1;

    // 256 retires wrap the 8-bit counter back to zero; the final J fetch observes it.
    for (int i = 0; i < 256; i++) run_j();
    run_j();
    checks++;
    if (bus.retired !== exp_ret) begin
        failures++;
        $display("FAIL wrap: got %h expected %h", bus.retired, exp_ret);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
